pc_redirect_unit: RTL and testbench
===================================

# pc_redirect_unit

Fetch-side consumer of the `pc_mux_select` code produced by the forwarding unit. Owns the program counter, drives the instruction-memory request/acknowledge handshake, applies redirects from every pipeline stage, and emits the squash vector for the pipeline registers `pr1`–`pr4`. It sits between the forwarding unit, the instruction memory and the `pr1` (IF/ID) register.

## Interface

Parameters:
- `WIDTH`, 16: PC and data width.
- `RESET_PC`, 16'h0000: PC value loaded at reset.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `pc_mux_select` input 3: redirect code. 0 = none, 1 = `rb`, 2 = `c`, 3 = `m`, 4 = `one`, 5 = `h`, 6 = `a`, 7 = reserved and treated as 0.
- `rb_data`, `c_data`, `m_target`, `one_target`, `h_data`, `a_data` input WIDTH each: target for codes 1–6 in that order.
- `stall` input 1: hazard stall; `pr1` cannot accept an instruction.
- `imem_ack` input 1: instruction memory returns data this cycle. May be high in the same cycle as `imem_req`.
- `imem_req` output 1: fetch request.
- `imem_addr` output WIDTH: fetch address, always equal to `pc`.
- `if_valid` output 1: the instruction returned this cycle is to be written into `pr1`.
- `if_pc` output WIDTH: PC of that instruction.
- `flush_pr` output 4: bit *k-1* squashes `pr`*k* at the next edge.

## Operation

- **Registers:**
  - `pc` (WIDTH).
  - `busy`: an unacknowledged request is outstanding.
  - `state`, with values RUN and PEND.
  - `pend_pc` (WIDTH).
- **Redirect target:** the target is selected by `pc_mux_select`. `redir` = (code is in 1..6).
- **Fetch request:** `imem_req` = `busy` | !`stall`. It is 0 while `rst_n`=0.
- **Outstanding request:**
  - `busy` sets on `imem_req` & !`imem_ack`.
  - `busy` clears on `imem_ack`.
  - While `busy`=1, `imem_addr` must not change.
- **RUN state:**
  - ack & !stall & !redir: `if_valid`=1, `if_pc`=`pc`, `pc` <= `pc`+1 (modulo 2^WIDTH, FFFF wraps to 0000).
  - ack & stall & !redir: `if_valid`=0 and `pc` holds. The instruction is discarded and refetched at the same PC.
  - redir and (ack or !busy-after-this-cycle): `pc` <= target, `if_valid`=0, stay RUN.
  - redir while a request stays outstanding (`imem_req` & !`imem_ack`): `pend_pc` <= target, go to PEND. `pc` holds.
- **PEND state:**
  - `if_valid`=0 always.
  - A new redir overwrites `pend_pc`, so the latest redirect wins. A later redirect always comes from an older, deeper instruction.
  - On ack: `pc` <= `pend_pc`, or the current-cycle target if redir is also asserted; go to RUN.
- **Redirect has priority over stall.** A redirect is never dropped, regardless of `stall`.
- **Squash vector (combinational from the code):**
  - `c` (WB): `flush_pr`=4'b1111.
  - `a` (MEM): 4'b0111.
  - `one` or `rb` (EX): 4'b0011.
  - `m` or `h` (RR/ID): 4'b0001.
  - Otherwise: 4'b0000.

## Timing

- **Reset values:** `pc`=RESET_PC, `busy`=0, `state`=RUN, `pend_pc`=0, `imem_req`=0, `if_valid`=0, `if_pc`=RESET_PC, `flush_pr`=0.
  - Reset asserted mid-transaction abandons the transaction. Any `imem_ack` arriving after reset is ignored until `imem_req` is reasserted.
- **After reset release:** `imem_req`=1 in the first cycle (unless `stall`), with `imem_addr`=RESET_PC.
- **Latency:**
  - Ack cycle to `pc`+1 visible on `imem_addr`: 1 edge.
  - Redirect code to target on `imem_addr`: 1 edge if no fetch is outstanding, otherwise 1 edge after the ack.
- **`if_valid`, `if_pc`, `flush_pr`:** combinational in the ack/select cycle. `pr1`–`pr4` capture them at the same edge.
- **Zero-wait memory** (ack same cycle as req): one instruction per cycle.

## Test plan

- Reset with RESET_PC=16'h0010, `imem_ack` tied 1, no stall → `imem_addr` 0010, 0011, 0012 on successive cycles; `if_valid`=1 each cycle.
- `pc_mux_select`=4, `one_target`=16'h0040, ack=1 → `if_valid`=0, `flush_pr`=0011, next `imem_addr`=0040.
- Request outstanding (ack low 3 cycles), `pc_mux_select`=6, `a_data`=16'h0080 in cycle 1 and `pc_mux_select`=2, `c_data`=16'h0090 in cycle 2 → address stable until ack, then `imem_addr`=0090, no `if_valid` pulse.
- `stall`=1 for 2 cycles with ack=1 at PC 0005 → `if_valid`=0, PC holds 0005; after stall drops, 0005 is delivered with `if_valid`=1.
- PC 16'hFFFF, ack=1 → next `imem_addr`=0000. Then `rst_n` pulled low while busy → all outputs at reset values immediately.

Source files
------------

// File: rtl/pc_redirect_unit.sv
// Fetch-side PC owner: drives the instruction-memory handshake, applies redirects
// from every pipeline stage, and produces the squash vector for pr1..pr4.
module pc_redirect_unit #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       pc_mux_select,
    input  logic [WIDTH-1:0] rb_data,
    input  logic [WIDTH-1:0] c_data,
    input  logic [WIDTH-1:0] m_target,
    input  logic [WIDTH-1:0] one_target,
    input  logic [WIDTH-1:0] h_data,
    input  logic [WIDTH-1:0] a_data,
    input  logic             stall,
    input  logic             imem_ack,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    output logic             if_valid,
    output logic [WIDTH-1:0] if_pc,
    output logic [3:0]       flush_pr
);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] pc_r, pc_s;
    logic [WIDTH-1:0] pend_pc_r, pend_pc_s;
    logic             busy_r, busy_s;
    logic [WIDTH-1:0] target_s;
    logic             redir_s;
    logic             req_s;
    logic             ack_s;
    logic             valid_s;

    // Redirect target and squash vector, both decoded from the select code.
    always_comb begin
        target_s = {WIDTH{1'b0}};
        redir_s  = 1'b0;
        flush_pr = 4'b0000;
        case (pc_mux_select)
            3'd1: begin target_s = rb_data;    redir_s = 1'b1; flush_pr = 4'b0011; end
            3'd2: begin target_s = c_data;     redir_s = 1'b1; flush_pr = 4'b1111; end
            3'd3: begin target_s = m_target;   redir_s = 1'b1; flush_pr = 4'b0001; end
            3'd4: begin target_s = one_target; redir_s = 1'b1; flush_pr = 4'b0011; end
            3'd5: begin target_s = h_data;     redir_s = 1'b1; flush_pr = 4'b0001; end
            3'd6: begin target_s = a_data;     redir_s = 1'b1; flush_pr = 4'b0111; end
            default: begin
                target_s = {WIDTH{1'b0}};
                redir_s  = 1'b0;
                flush_pr = 4'b0000;
            end
        endcase
        if (!rst_n) begin
            flush_pr = 4'b0000;
        end else begin
            flush_pr = flush_pr;
        end
    end

    // An ack only counts against a request we are actually making, so stray
    // acks after reset are ignored.
    assign req_s     = rst_n & (busy_r | ~stall);
    assign ack_s     = req_s & imem_ack;
    assign imem_req  = req_s;
    assign imem_addr = pc_r;
    assign if_pc     = pc_r;
    assign if_valid  = valid_s;

    // Next-state, next-PC and delivery decision.
    always_comb begin
        state_s   = state_r;
        pc_s      = pc_r;
        pend_pc_s = pend_pc_r;
        busy_s    = busy_r;
        valid_s   = 1'b0;

        if (ack_s) begin
            busy_s = 1'b0;
        end else if (req_s) begin
            busy_s = 1'b1;
        end else begin
            busy_s = busy_r;
        end

        case (state_r)
            RUN: begin
                if (redir_s) begin
                    // Address must stay frozen while a request is outstanding.
                    if (ack_s || !busy_s) begin
                        pc_s = target_s;
                    end else begin
                        pend_pc_s = target_s;
                        state_s   = PEND;
                    end
                end else if (ack_s && !stall) begin
                    valid_s = 1'b1;
                    pc_s    = pc_r + {{(WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    pc_s = pc_r;
                end
            end
            PEND: begin
                if (redir_s) begin
                    pend_pc_s = target_s;
                end else begin
                    pend_pc_s = pend_pc_r;
                end
                if (ack_s) begin
                    pc_s    = redir_s ? target_s : pend_pc_r;
                    state_s = RUN;
                end else begin
                    pc_s = pc_r;
                end
            end
            default: begin
                state_s = RUN;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= RUN;
            pc_r      <= RESET_PC;
            pend_pc_r <= {WIDTH{1'b0}};
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            pc_r      <= pc_s;
            pend_pc_r <= pend_pc_s;
            busy_r    <= busy_s;
        end
    end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Table-driven scoreboard bench for pc_redirect_unit (RESET_PC = 16'h0010).
module tb_pc_redirect_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  pc_mux_select;
    logic [15:0] rb_data, c_data, m_target, one_target, h_data, a_data;
    logic        stall, imem_ack;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        if_valid;
    logic [15:0] if_pc;
    logic [3:0]  flush_pr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_redirect_unit #(.WIDTH(16), .RESET_PC(16'h0010)) dut (
        .clk(clk), .rst_n(rst_n), .pc_mux_select(pc_mux_select),
        .rb_data(rb_data), .c_data(c_data), .m_target(m_target),
        .one_target(one_target), .h_data(h_data), .a_data(a_data),
        .stall(stall), .imem_ack(imem_ack), .imem_req(imem_req),
        .imem_addr(imem_addr), .if_valid(if_valid), .if_pc(if_pc),
        .flush_pr(flush_pr)
    );

    typedef struct {
        logic [2:0]  sel;
        logic [15:0] tgt;
        logic        stl;
        logic        ack;
        logic        req;
        logic [15:0] addr;
        logic        vld;
        logic [3:0]  flush;
    } vec_t;

    typedef struct {
        logic        req;
        logic [15:0] addr;
        logic        vld;
        logic [3:0]  flush;
        int          idx;
    } exp_t;

    vec_t vecs[27];
    exp_t sb[$];

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, expv);
        end
    endtask

    task automatic drive(input vec_t v);
        pc_mux_select = v.sel;
        stall         = v.stl;
        imem_ack      = v.ack;
        rb_data       = (v.sel == 3'd1) ? v.tgt : 16'hA001;
        c_data        = (v.sel == 3'd2) ? v.tgt : 16'hA002;
        m_target      = (v.sel == 3'd3) ? v.tgt : 16'hA003;
        one_target    = (v.sel == 3'd4) ? v.tgt : 16'hA004;
        h_data        = (v.sel == 3'd5) ? v.tgt : 16'hA005;
        a_data        = (v.sel == 3'd6) ? v.tgt : 16'hA006;
    endtask

    task automatic compare_head();
        exp_t e;
        if (sb.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            chk("imem_req", e.idx, {15'd0, imem_req}, {15'd0, e.req});
            chk("imem_addr", e.idx, imem_addr, e.addr);
            chk("if_valid", e.idx, {15'd0, if_valid}, {15'd0, e.vld});
            chk("flush_pr", e.idx, {12'd0, flush_pr}, {12'd0, e.flush});
            if (e.vld) chk("if_pc", e.idx, if_pc, e.addr);
        end
    endtask

    // Drive one cycle after the edge, push its expectation, check at negedge.
    task automatic apply(input vec_t v, input int idx);
        drive(v);
        sb.push_back('{req: v.req, addr: v.addr, vld: v.vld, flush: v.flush, idx: idx});
        @(negedge clk);
        compare_head();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            sel   tgt       stl   ack   req   addr      vld   flush
        vecs[0]  = '{3'd0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0010, 1'b1, 4'b0000};
        vecs[1]  = '{3'd0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0011, 1'b1, 4'b0000};
        vecs[2]  = '{3'd0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0012, 1'b1, 4'b0000};
        vecs[3]  = '{3'd4, 16'h0040, 1'b0, 1'b1, 1'b1, 16'h0013, 1'b0, 4'b0011};
        vecs[4]  = '{3'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0040, 1'b0, 4'b0000};
        vecs[5]  = '{3'd6, 16'h0080, 1'b0, 1'b0, 1'b1, 16'h0040, 1'b0, 4'b0111};
        vecs[6]  = '{3'd2, 16'h0090, 1'b0, 1'b0, 1'b1, 16'h0040, 1'b0, 4'b1111};
        vecs[7]  = '{3'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0040, 1'b0, 4'b0000};
        vecs[8]  = '{3'd0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0040, 1'b0, 4'b0000};
        vecs[9]  = '{3'd0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0090, 1'b1, 4'b0000};
        vecs[10] = '{3'd1, 16'h0005, 1'b0, 1'b1, 1'b1, 16'h0091, 1'b0, 4'b0011};
        vecs[11] = '{3'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0005, 1'b0, 4'b0000};
        vecs[12] = '{3'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0005, 1'b0, 4'b0000};
        vecs[13] = '{3'd0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0005, 1'b1, 4'b0000};
        vecs[14] = '{3'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0006, 1'b0, 4'b0000};
        vecs[15] = '{3'd0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0006, 1'b0, 4'b0000};
        vecs[16] = '{3'd0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0006, 1'b1, 4'b0000};
        vecs[17] = '{3'd3, 16'h0100, 1'b1, 1'b0, 1'b0, 16'h0007, 1'b0, 4'b0001};
        vecs[18] = '{3'd5, 16'h0200, 1'b0, 1'b1, 1'b1, 16'h0100, 1'b0, 4'b0001};
        vecs[19] = '{3'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0200, 1'b0, 4'b0000};
        vecs[20] = '{3'd6, 16'h0300, 1'b0, 1'b0, 1'b1, 16'h0200, 1'b0, 4'b0111};
        vecs[21] = '{3'd3, 16'h0400, 1'b0, 1'b1, 1'b1, 16'h0200, 1'b0, 4'b0001};
        vecs[22] = '{3'd7, 16'h0BAD, 1'b0, 1'b1, 1'b1, 16'h0400, 1'b1, 4'b0000};
        vecs[23] = '{3'd0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0401, 1'b1, 4'b0000};
        vecs[24] = '{3'd4, 16'hFFFF, 1'b0, 1'b1, 1'b1, 16'h0402, 1'b0, 4'b0011};
        vecs[25] = '{3'd0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b1, 4'b0000};
        vecs[26] = '{3'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 4'b0000};

        // Reset held with live-looking inputs: outputs must sit at reset values.
        rst_n = 1'b0;
        drive('{3'd4, 16'h0040, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b0000});
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", -1, {15'd0, imem_req}, 16'h0000);
        chk("rst_addr", -1, imem_addr, 16'h0010);
        chk("rst_valid", -1, {15'd0, if_valid}, 16'h0000);
        chk("rst_if_pc", -1, if_pc, 16'h0010);
        chk("rst_flush", -1, {12'd0, flush_pr}, 16'h0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 27; i++) begin
            apply(vecs[i], i);
        end

        // Busy at PC 0000 (vector 26 left the request unacked): async reset
        // mid-transaction with a live redirect code and ack on the inputs.
        drive('{3'd2, 16'h0777, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 4'b0000});
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_req", 100, {15'd0, imem_req}, 16'h0000);
        chk("midrst_addr", 100, imem_addr, 16'h0010);
        chk("midrst_valid", 100, {15'd0, if_valid}, 16'h0000);
        chk("midrst_if_pc", 100, if_pc, 16'h0010);
        chk("midrst_flush", 100, {12'd0, flush_pr}, 16'h0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply('{3'd0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0010, 1'b1, 4'b0000}, 101);
        apply('{3'd0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0011, 1'b1, 4'b0000}, 102);

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
